// File: rtl/trapez_peak_detector.sv
// Peak detector for the trapezoidal shaper: threshold trigger, flat-top window, width and pile-up.
// Define TRAPEZ_PEAK_AVERAGE_EN to report the window mean instead of the window maximum.
module trapez_peak_detector #(
   parameter int unsigned DATA_SIZE        = 16,
   parameter int unsigned TS_SIZE          = 32,
   parameter int unsigned FLAT_DELAY       = 4,
   parameter int unsigned PEAK_WINDOW_LOG2 = 2,
   parameter int unsigned HYST             = 16,
   parameter int unsigned MAX_WIDTH        = 64,
   parameter int unsigned HOLDOFF          = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic signed [DATA_SIZE-1:0] input_data,
   input  logic                        input_data_valid,
   input  logic signed [DATA_SIZE-1:0] threshold,
   output logic signed [DATA_SIZE-1:0] peak_data,
   output logic        [TS_SIZE-1:0]   peak_timestamp,
   output logic        [15:0]          peak_width,
   output logic                        peak_pileup,
   output logic                        peak_valid
);
   localparam int unsigned WIN_LEN = 2 ** PEAK_WINDOW_LOG2;
   localparam int unsigned RISE_W  = $clog2(FLAT_DELAY + 1);
   localparam int unsigned HOLD_W  = $clog2(HOLDOFF + 2);
   localparam int unsigned WIN_W   = PEAK_WINDOW_LOG2 + 1;

   typedef enum logic [2:0] {StIdle, StRise, StSample, StWaitFall, StHoldoff} state_e;

   state_e                      state_q;
   logic [TS_SIZE-1:0]          ts_q, ts_lat_q;
   logic [15:0]                 width_q, width_inc;
   logic                        pileup_q;
   logic [RISE_W-1:0]           rise_cnt_q;
   logic [WIN_W-1:0]            win_cnt_q;
   logic [HOLD_W-1:0]           hold_cnt_q;
   logic signed [DATA_SIZE:0]   in_ext, fall_level;
   logic                        above_thr, below_fall;
   logic                        rise_last, win_last, hold_done, win_take;
   logic signed [DATA_SIZE-1:0] result;

`ifdef TRAPEZ_PEAK_AVERAGE_EN
   localparam int unsigned ACC_W = DATA_SIZE + PEAK_WINDOW_LOG2;
   logic signed [ACC_W-1:0] acc_q, acc_mean;
   // Short pulses still divide by the full window length.
   assign acc_mean = acc_q >>> PEAK_WINDOW_LOG2;
   assign result   = acc_mean[DATA_SIZE-1:0];
`else
   logic signed [DATA_SIZE-1:0] max_q;
   assign result = max_q;
`endif

   // One extra bit so threshold - HYST cannot wrap.
   assign in_ext     = $signed({input_data[DATA_SIZE-1], input_data});
   assign fall_level = $signed({threshold[DATA_SIZE-1], threshold})
                       - $signed({1'b0, DATA_SIZE'(HYST)});
   assign above_thr  = input_data >= threshold;
   assign below_fall = in_ext < fall_level;
   assign rise_last  = 32'(rise_cnt_q) + 32'd1 >= FLAT_DELAY;
   assign win_last   = 32'(win_cnt_q) + 32'd1 >= WIN_LEN;
   assign hold_done  = 32'(hold_cnt_q) + 32'd1 >= HOLDOFF;
   assign width_inc  = (width_q == 16'hFFFF) ? width_q : width_q + 16'd1;
   assign win_take   = input_data_valid && !below_fall &&
                       (state_q == StSample || (state_q == StRise && rise_last));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= StIdle;
         ts_q           <= '0;
         ts_lat_q       <= '0;
         width_q        <= '0;
         pileup_q       <= 1'b0;
         rise_cnt_q     <= '0;
         win_cnt_q      <= '0;
         hold_cnt_q     <= '0;
`ifdef TRAPEZ_PEAK_AVERAGE_EN
         acc_q          <= '0;
`else
         max_q          <= '0;
`endif
         peak_data      <= '0;
         peak_timestamp <= '0;
         peak_width     <= '0;
         peak_pileup    <= 1'b0;
         peak_valid     <= 1'b0;
      end else begin
         peak_valid <= 1'b0;
         if (input_data_valid) begin
            ts_q <= ts_q + TS_SIZE'(1);
            if (win_take) win_cnt_q <= win_cnt_q + WIN_W'(1);
`ifdef TRAPEZ_PEAK_AVERAGE_EN
            if (win_take) acc_q <= acc_q + ACC_W'(input_data);
`else
            if (win_take && (win_cnt_q == '0 || input_data > max_q)) max_q <= input_data;
`endif
            unique case (state_q)
               StIdle: begin
                  if (above_thr) begin
                     state_q    <= StRise;
                     ts_lat_q   <= ts_q;
                     width_q    <= 16'd1;
                     pileup_q   <= (MAX_WIDTH == 0);
                     rise_cnt_q <= '0;
                     win_cnt_q  <= '0;
`ifdef TRAPEZ_PEAK_AVERAGE_EN
                     acc_q      <= '0;
`else
                     max_q      <= '0;
`endif
                  end
               end
               StRise, StSample, StWaitFall: begin
                  if (below_fall) begin
                     state_q    <= StHoldoff;
                     hold_cnt_q <= '0;
                     // Falling before the window completes is a short pulse.
                     if (state_q != StWaitFall) pileup_q <= 1'b1;
                  end else begin
                     width_q <= width_inc;
                     if (32'(width_inc) > MAX_WIDTH) pileup_q <= 1'b1;
                     if (state_q == StRise) begin
                        rise_cnt_q <= rise_cnt_q + RISE_W'(1);
                        if (rise_last) state_q <= win_last ? StWaitFall : StSample;
                     end else if (state_q == StSample && win_last) begin
                        state_q <= StWaitFall;
                     end
                  end
               end
               StHoldoff: begin
                  if (above_thr) pileup_q <= 1'b1;
                  if (!hold_done) hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                  if (hold_done && !above_thr) begin
                     state_q        <= StIdle;
                     peak_valid     <= 1'b1;
                     peak_data      <= result;
                     peak_timestamp <= ts_lat_q;
                     peak_width     <= width_q;
                     peak_pileup    <= pileup_q;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trapez_peak_detector.sv
// Bench for trapez_peak_detector: an array-scan reference model queues expected results,
// an independent monitor checks every peak_valid strobe against the queue.
`timescale 1ns/1ps
module tb_trapez_peak_detector;
   localparam int DW   = 16;
   localparam int TSW  = 32;
   localparam int FD   = 4;
   localparam int WL   = 2;
   localparam int WIN  = 4;
   localparam int HY   = 16;
   localparam int MAXW = 64;
   localparam int HO   = 8;

   logic                  clk = 1'b0;
   logic                  reset_n = 1'b0;
   logic signed [DW-1:0]  input_data = '0;
   logic                  input_data_valid = 1'b0;
   logic signed [DW-1:0]  threshold = 16'sd100;
   logic signed [DW-1:0]  peak_data;
   logic [TSW-1:0]        peak_timestamp;
   logic [15:0]           peak_width;
   logic                  peak_pileup;
   logic                  peak_valid;

   always #5 clk = ~clk;

   trapez_peak_detector #(
      .DATA_SIZE(DW), .TS_SIZE(TSW), .FLAT_DELAY(FD), .PEAK_WINDOW_LOG2(WL),
      .HYST(HY), .MAX_WIDTH(MAXW), .HOLDOFF(HO)
   ) dut (
      .clk(clk), .reset_n(reset_n), .input_data(input_data),
      .input_data_valid(input_data_valid), .threshold(threshold),
      .peak_data(peak_data), .peak_timestamp(peak_timestamp), .peak_width(peak_width),
      .peak_pileup(peak_pileup), .peak_valid(peak_valid)
   );

   typedef struct {
      int     data;
      longint ts;
      int     width;
      int     pileup;
      longint idx;
   } exp_t;

   exp_t   exp_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;
   longint n_cons;
   int     last_data, last_width, last_pu;
   longint last_ts;

`ifdef TRAPEZ_PEAK_AVERAGE_EN
   localparam int P1_PEAK = 603;
`else
   localparam int P1_PEAK = 610;
`endif

   task automatic check(input string name, input longint act, input longint req);
      n_tests++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Valid samples consumed since reset; a strobe must follow the sample that ends holdoff.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) n_cons <= 0;
      else if (input_data_valid) n_cons <= n_cons + 1;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n && peak_valid) begin
         last_data  = int'(peak_data);
         last_ts    = longint'(peak_timestamp);
         last_width = int'(peak_width);
         last_pu    = int'(peak_pileup);
         check("strobe_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("peak_data", last_data, e.data);
            check("peak_timestamp", last_ts, e.ts);
            check("peak_width", last_width, e.width);
            check("peak_pileup", last_pu, e.pileup);
            check("strobe_latency", n_cons, e.idx);
         end
      end
   end

   // Scan the valid-sample stream: crossing, fall, window, then holdoff end.
   task automatic run_model(input int s[$], input int thr, input longint base);
      int n, fl, i, c, f, e, cnt, best, w, pu;
      longint sum;
      exp_t x;
      n = s.size();
      fl = thr - HY;
      i = 0;
      while (i < n) begin
         c = -1;
         for (int j = i; j < n; j++) if (s[j] >= thr) begin c = j; break; end
         if (c < 0) break;
         f = -1;
         for (int j = c + 1; j < n; j++) if (s[j] < fl) begin f = j; break; end
         if (f < 0) break;
         cnt = 0; best = 0; sum = 0;
         for (int j = c + FD; j < c + FD + WIN && j < f; j++) begin
            if (cnt == 0 || s[j] > best) best = s[j];
            sum += s[j];
            cnt++;
         end
         pu = (cnt < WIN) ? 1 : 0;
         w = f - c;
         if (w > MAXW) pu = 1;
         if (w > 65535) w = 65535;
         e = -1;
         for (int j = f + 1; j < n; j++) begin
            if (s[j] >= thr) pu = 1;
            else if (j >= f + HO) begin e = j; break; end
         end
         if (e < 0) break;
`ifdef TRAPEZ_PEAK_AVERAGE_EN
         x.data = int'(sum >>> WL);
`else
         x.data = best;
`endif
         x.ts = base + c;
         x.width = w;
         x.pileup = pu;
         x.idx = base + e + 1;
         exp_q.push_back(x);
         i = e + 1;
      end
   endtask

   // gap_mode: 0 contiguous, 1 invalid cycle before every sample, 2 random gaps.
   task automatic drive(input int s[$], input int thr, input int gap_mode);
      threshold = DW'(thr);
      foreach (s[k]) begin
         if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
            @(negedge clk);
            input_data_valid = 1'b0;
            input_data = DW'($urandom);
         end
         @(negedge clk);
         input_data_valid = 1'b1;
         input_data = DW'(s[k]);
      end
      @(negedge clk);
      input_data_valid = 1'b0;
      input_data = '0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      input_data_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      check("rst_peak_data", longint'(peak_data), 0);
      check("rst_peak_timestamp", longint'(peak_timestamp), 0);
      check("rst_peak_width", longint'(peak_width), 0);
      check("rst_peak_pileup", longint'(peak_pileup), 0);
      check("rst_peak_valid", longint'(peak_valid), 0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic segment(input string name, input int s[$], input int thr, input int gap_mode,
                          input bit do_reset);
      if (do_reset) apply_reset();
      run_model(s, thr, n_cons);
      drive(s, thr, gap_mode);
      repeat (3) @(negedge clk);
      check({name, "_pending"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic check_last(input string name, input int d, input longint ts, input int w,
                             input int pu);
      check({name, "_data"}, last_data, d);
      check({name, "_ts"}, last_ts, ts);
      check({name, "_width"}, last_width, w);
      check({name, "_pileup"}, last_pu, pu);
   endtask

   task automatic gen_random(output int s[$], input int thr);
      int h, rise, top, fall;
      s = {};
      while (s.size() < 250) begin
         if ($urandom_range(0, 9) < 6) begin
            s.push_back(int'($urandom_range(0, 60)) - 30);
         end else begin
            h    = thr - 40 + int'($urandom_range(0, 1500));
            rise = int'($urandom_range(0, 4));
            top  = int'($urandom_range(1, 90));
            fall = int'($urandom_range(0, 4));
            for (int k = 1; k <= rise; k++) s.push_back(h * k / (rise + 1));
            for (int k = 0; k < top; k++) s.push_back(h + int'($urandom_range(0, 20)) - 10);
            for (int k = fall; k >= 1; k--) s.push_back(h * k / (fall + 1));
         end
      end
      for (int k = 0; k < HO + 4; k++) s.push_back(0);
   endtask

   initial begin : timeout
      #5ms;
      $display("FAIL timeout: got no finish, expected finish before 5ms");
      $fatal(1, "timeout");
   end

   initial begin : main
      int p1[$], s[$], thr;
      p1 = '{0, 50, 150, 300, 500, 600, 600, 610, 605, 600, 590, 400, 200, 50};

      s = p1; repeat (10) s.push_back(0);
      segment("basic", s, 100, 0, 1'b1);
      check_last("basic", P1_PEAK, 2, 11, 0);

      segment("gapped", s, 100, 1, 1'b1);
      check_last("gapped", P1_PEAK, 2, 11, 0);

      s = p1; s.push_back(0); s.push_back(0); s.push_back(300); repeat (12) s.push_back(0);
      segment("holdoff_cross", s, 100, 0, 1'b1);
      check_last("holdoff_cross", P1_PEAK, 2, 11, 1);

      s = '{0, 150, 40}; repeat (12) s.push_back(0);
      segment("short", s, 100, 0, 1'b1);
      check_last("short", 0, 1, 1, 1);

      s = '{0}; repeat (80) s.push_back(500); repeat (12) s.push_back(0);
      segment("long", s, 100, 0, 1'b1);
      check_last("long", 500, 1, 80, 1);

      // Stop mid-window and reset for one cycle; no strobe may come from the cut pulse.
      s = p1[0:7];
      segment("cut", s, 100, 0, 1'b0);
      apply_reset();
      s = p1; repeat (10) s.push_back(0);
      segment("after_reset", s, 100, 0, 1'b0);
      check_last("after_reset", P1_PEAK, 2, 11, 0);

      for (int r = 0; r < 8; r++) begin
         thr = int'($urandom_range(50, 400));
         gen_random(s, thr);
         segment("random", s, thr, 2, r[0]);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
